flit_rx_queue: RTL and testbench

Receive-side elastic buffer for the chip-to-chip flit link. The link carries a 128-bit flit with a single valid strobe and has no backpressure. This block captures every valid flit arriving on `flit_rx`/`flit_rx_vld` into a small FIFO and presents it to the local router through a ready/valid handshake. When the FIFO cannot accept a flit, the block drops it and counts the loss.

---
 rtl/flit_pkg.sv | 13 +
 rtl/flit_rx_queue_if.sv | 12 +
 rtl/sync_fifo.sv | 37 +++
 rtl/flit_rx_queue.sv | 43 ++++
 tb/tb_flit_rx_queue.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/flit_pkg.sv
// flit_pkg: flit type, link status record and pointer sizing shared by the flit link blocks
package flit_pkg;
  localparam int FLIT_WIDTH = 128;
  localparam int CNT_WIDTH = 16;
  typedef logic [FLIT_WIDTH-1:0] flit_t;
  typedef struct packed {
    logic                 overflow;
    logic [CNT_WIDTH-1:0] drop_cnt;
  } link_status_t;
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/flit_rx_queue_if.sv
// flit_rx_queue_if: link-side flit strobe plus router-side ready/valid handshake
interface flit_rx_queue_if import flit_pkg::*; #(
  parameter int FLIT_WIDTH = flit_pkg::FLIT_WIDTH
);
  logic [FLIT_WIDTH-1:0] flit_rx;
  logic                  flit_rx_vld;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  out_vld;
  logic                  out_rdy;
  modport master (output flit_rx, flit_rx_vld, out_rdy, input out_flit, out_vld);
  modport slave (input flit_rx, flit_rx_vld, out_rdy, output out_flit, out_vld);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: wrap-bit pointer FIFO; caller must not push when full unless also popping
module sync_fifo import flit_pkg::*; #(
  parameter int WIDTH = FLIT_WIDTH,
  parameter int DEPTH = 4,
  localparam int PW = ptr_width(DEPTH),
  localparam int AW = PW - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // when full with a pop, the write lands on the slot the head is leaving
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/flit_rx_queue.sv
// flit_rx_queue: no-backpressure link flits into a FIFO; drops and counts flits that do not fit
module flit_rx_queue import flit_pkg::*; #(
  parameter int FLIT_WIDTH = flit_pkg::FLIT_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = flit_pkg::CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  flit_rx_queue_if.slave               link,
  output logic [ptr_width(DEPTH)-1:0]  occupancy,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         drop_cnt,
  input  logic                         clr_stat
);
  logic [FLIT_WIDTH-1:0] head;
  logic full, empty, push, pop, drop;
  assign link.out_vld  = !empty;
  assign pop           = link.out_vld && link.out_rdy;
  assign push          = link.flit_rx_vld && (!full || pop);
  assign drop          = link.flit_rx_vld && full && !pop;
  assign link.out_flit = link.out_vld ? head : '0;
  sync_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (link.flit_rx),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );
  // clearing beats a coincident drop, so that drop goes uncounted
  always_ff @(posedge clk) begin
    if (rst || clr_stat) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_flit_rx_queue.sv
// tb_flit_rx_queue: directed checks on a default queue and a 4-bit-counter twin driven in lockstep
module tb_flit_rx_queue;
  import flit_pkg::*;
  logic clk = 1'b0;
  logic rst, clr_stat;
  logic [2:0] occ_a, occ_b;
  logic ov_a, ov_b;
  logic [15:0] cnt_a;
  logic [3:0] cnt_b;
  int checks = 0;
  int fails = 0;
  flit_rx_queue_if ifa ();
  flit_rx_queue_if ifb ();
  assign ifb.flit_rx     = ifa.flit_rx;
  assign ifb.flit_rx_vld = ifa.flit_rx_vld;
  assign ifb.out_rdy     = ifa.out_rdy;
  always #5 clk = ~clk;
  flit_rx_queue dut_a (
    .clk(clk), .rst(rst), .link(ifa.slave), .occupancy(occ_a),
    .overflow(ov_a), .drop_cnt(cnt_a), .clr_stat(clr_stat)
  );
  flit_rx_queue #(.CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .link(ifb.slave), .occupancy(occ_b),
    .overflow(ov_b), .drop_cnt(cnt_b), .clr_stat(clr_stat)
  );
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int bad;
    logic [127:0] exp_q [4];
    rst = 1'b1;
    clr_stat = 1'b0;
    ifa.flit_rx = '0;
    ifa.flit_rx_vld = 1'b0;
    ifa.out_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_vld", ifa.out_vld, 0);
    check("rst_flit", ifa.out_flit, 0);
    check("rst_occ", occ_a, 0);
    check("rst_ov", ov_a, 0);
    check("rst_cnt", cnt_a, 0);
    // single flit, one-cycle latency, consumed immediately
    ifa.out_rdy = 1'b1;
    ifa.flit_rx = {16{8'hA5}};
    ifa.flit_rx_vld = 1'b1;
    tick();
    ifa.flit_rx_vld = 1'b0;
    check("one_vld", ifa.out_vld, 1);
    check("one_flit", ifa.out_flit, {16{8'hA5}});
    check("one_occ", occ_a, 1);
    tick();
    check("one_gone_vld", ifa.out_vld, 0);
    check("one_gone_flit", ifa.out_flit, 0);
    check("one_gone_occ", occ_a, 0);
    // six flits into a stalled queue: 5 and 6 dropped
    ifa.out_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      ifa.flit_rx = 128'(i);
      ifa.flit_rx_vld = 1'b1;
      tick();
      if (i == 4) check("full_no_ov", ov_a, 0);
    end
    check("fill_occ", occ_a, 4);
    check("fill_ov", ov_a, 1);
    check("fill_cnt", cnt_a, 2);
    check("fill_head", ifa.out_flit, 1);
    // push and pop together while full
    ifa.flit_rx = 128'd7;
    ifa.out_rdy = 1'b1;
    tick();
    ifa.flit_rx_vld = 1'b0;
    check("pp_occ", occ_a, 4);
    check("pp_cnt", cnt_a, 2);
    exp_q = '{128'd2, 128'd3, 128'd4, 128'd7};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), ifa.out_flit, exp_q[i]);
      tick();
    end
    check("drain_occ", occ_a, 0);
    check("drain_vld", ifa.out_vld, 0);
    // long streaming run, pointers wrap many times
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      ifa.flit_rx = 128'(i + 1000);
      ifa.flit_rx_vld = 1'b1;
      tick();
      if (ifa.out_flit !== 128'(i + 1000) || occ_a !== 3'd1 || ifa.out_vld !== 1'b1) bad++;
    end
    ifa.flit_rx_vld = 1'b0;
    tick();
    check("stream_bad", 128'(bad), 0);
    check("stream_cnt", cnt_a, 2);
    check("stream_occ", occ_a, 0);
    // clear, then 4 stored plus 20 drops
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    check("clr_cnt", cnt_a, 0);
    check("clr_ov", ov_a, 0);
    ifa.out_rdy = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ifa.flit_rx = 128'(100 + i);
      ifa.flit_rx_vld = 1'b1;
      tick();
    end
    check("sat_occ", occ_a, 4);
    check("sat_cnt16", cnt_a, 20);
    check("sat_cnt4", cnt_b, 15);
    check("sat_ov4", ov_b, 1);
    // clear coincident with a drop
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    ifa.flit_rx_vld = 1'b0;
    check("clrdrop_cnt16", cnt_a, 0);
    check("clrdrop_cnt4", cnt_b, 0);
    check("clrdrop_ov", ov_b, 0);
    check("clrdrop_occ", occ_a, 4);
    check("clrdrop_head", ifa.out_flit, 100);
    // reset with three entries and a flit arriving
    ifa.out_rdy = 1'b1;
    tick();
    ifa.out_rdy = 1'b0;
    check("pre_rst_occ", occ_a, 3);
    check("pre_rst_head", ifa.out_flit, 101);
    rst = 1'b1;
    ifa.flit_rx = 128'hDEAD;
    ifa.flit_rx_vld = 1'b1;
    tick();
    rst = 1'b0;
    ifa.flit_rx_vld = 1'b0;
    check("mrst_vld", ifa.out_vld, 0);
    check("mrst_occ", occ_a, 0);
    check("mrst_cnt", cnt_a, 0);
    check("mrst_flit", ifa.out_flit, 0);
    tick();
    check("mrst_still_occ", occ_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
